// File: rtl/pe_mac_accum.sv
// Windowed signed MAC: multiplies each sampled operand pair and sums the products with saturation.
// Each window close emits result/result_cnt/result_ovf with a one-cycle result_valid pulse.
// Ports: clk, rst (async active-low), data_in_valid, data_out_valid,
//   a_in, b_in -> result, result_cnt, result_ovf, result_valid, busy.
module pe_mac_accum #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 20,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_in_valid,
  input  logic                 data_out_valid,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic [ACC_WIDTH-1:0] result,
  output logic [CNT_WIDTH-1:0] result_cnt,
  output logic                 result_ovf,
  output logic                 result_valid,
  output logic                 busy
);

  localparam int PW = 2 * WIDTH;
  localparam int XW = ACC_WIDTH + 1 - PW;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX =
    {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN =
    {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN
  } state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        prod_q, prod_d;
  logic                 p_v_q, p_v_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0] result_q, result_d;
  logic [CNT_WIDTH-1:0] result_cnt_q, result_cnt_d;
  logic                 result_ovf_q, result_ovf_d;
  logic                 result_valid_q, result_valid_d;

  logic [PW-1:0]        a_ext, b_ext, mul;
  logic [ACC_WIDTH:0]   addend, sum;
  logic                 sum_ovf;
  logic [ACC_WIDTH-1:0] sum_sat;
  logic [CNT_WIDTH-1:0] cnt_inc;

  // Operands widened to the full product width so the
  // truncated product is the exact signed result.
  assign a_ext = {{WIDTH{a_in[WIDTH-1]}}, a_in};
  assign b_ext = {{WIDTH{b_in[WIDTH-1]}}, b_in};
  assign mul   = a_ext * b_ext;

  // One adder serves both accumulation and the final
  // drain add; both add the pending product if any.
  assign addend = p_v_q ? {{XW{prod_q[PW-1]}}, prod_q}
                        : '0;
  assign sum    = {acc_q[ACC_WIDTH-1], acc_q} + addend;

  assign sum_ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
  assign sum_sat = !sum_ovf       ? sum[ACC_WIDTH-1:0]
                 : sum[ACC_WIDTH] ? ACC_MIN
                 :                  ACC_MAX;

  assign cnt_inc = (p_v_q && !(&cnt_q)) ? cnt_q + 1'b1
                                        : cnt_q;

  always_comb begin
    state_d        = state_q;
    prod_d         = prod_q;
    p_v_d          = data_in_valid;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    ovf_d          = ovf_q;
    result_d       = result_q;
    result_cnt_d   = result_cnt_q;
    result_ovf_d   = result_ovf_q;
    result_valid_d = 1'b0;

    if (data_in_valid) begin
      prod_d = mul;
    end

    unique case (state_q)
      S_IDLE, S_ACCUM: begin
        if (p_v_q) begin
          acc_d = sum_sat;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | sum_ovf;
        end
        // Window close wins the state decision; the
        // coincident sample is still captured above.
        if (data_out_valid) begin
          state_d = S_DRAIN;
        end else if (data_in_valid) begin
          state_d = S_ACCUM;
        end
      end
      S_DRAIN: begin
        result_d       = sum_sat;
        result_cnt_d   = cnt_inc;
        result_ovf_d   = ovf_q | sum_ovf;
        result_valid_d = 1'b1;
        acc_d          = '0;
        cnt_d          = '0;
        ovf_d          = 1'b0;
        // A sample taken here opens the next window.
        state_d = data_in_valid ? S_ACCUM : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      prod_q         <= '0;
      p_v_q          <= 1'b0;
      acc_q          <= '0;
      cnt_q          <= '0;
      ovf_q          <= 1'b0;
      result_q       <= '0;
      result_cnt_q   <= '0;
      result_ovf_q   <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      prod_q         <= prod_d;
      p_v_q          <= p_v_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      ovf_q          <= ovf_d;
      result_q       <= result_d;
      result_cnt_q   <= result_cnt_d;
      result_ovf_q   <= result_ovf_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign result       = result_q;
  assign result_cnt   = result_cnt_q;
  assign result_ovf   = result_ovf_q;
  assign result_valid = result_valid_q;
  assign busy         = (state_q != S_IDLE) | p_v_q;

endmodule

// File: tb/tb_pe_mac_accum.sv
// Self-checking bench for pe_mac_accum: window-level model
// plus directed vectors with literal expected results.
module tb_pe_mac_accum;

  localparam int W  = 8;
  localparam int AW = 20;
  localparam int CW = 8;
  localparam int ACC_MAX = (1 << (AW - 1)) - 1;
  localparam int ACC_MIN = -(1 << (AW - 1));
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          div = 1'b0;
  logic          dov = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [AW-1:0] result;
  logic [CW-1:0] result_cnt;
  logic          result_ovf;
  logic          result_valid;
  logic          busy;

  int checks = 0;
  int errors = 0;

  pe_mac_accum #(
    .WIDTH(W),
    .ACC_WIDTH(AW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_in_valid(div),
    .data_out_valid(dov),
    .a_in(a),
    .b_in(b),
    .result(result),
    .result_cnt(result_cnt),
    .result_ovf(result_ovf),
    .result_valid(result_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input longint act,
                       input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d",
               nm, act, exp);
    end
  endtask

  // Window model: products queue up per window; a close
  // folds them with per-add saturation, emitted one edge on.
  int  win_q[$];
  bit  pend = 0;
  int  cl_res = 0;
  int  cl_cnt = 0;
  bit  cl_ovf = 0;
  bit  exp_valid = 0;
  int  exp_res = 0;
  int  exp_cnt = 0;
  bit  exp_ovf = 0;
  bit  exp_busy = 0;

  always @(posedge clk or negedge rst) begin
    bit exit_e;
    int s;
    if (!rst) begin
      win_q.delete();
      pend      = 0;
      exp_valid = 0;
      exp_res   = 0;
      exp_cnt   = 0;
      exp_ovf   = 0;
      exp_busy  = 0;
    end else begin
      exit_e    = pend;
      exp_valid = 0;
      if (pend) begin
        exp_valid = 1;
        exp_res   = cl_res;
        exp_cnt   = cl_cnt;
        exp_ovf   = cl_ovf;
        pend      = 0;
      end
      if (div)
        win_q.push_back(int'($signed(a)) * int'($signed(b)));
      if (dov && !exit_e) begin
        s      = 0;
        cl_ovf = 0;
        foreach (win_q[i]) begin
          s = s + win_q[i];
          if (s > ACC_MAX) begin
            s = ACC_MAX;
            cl_ovf = 1;
          end else if (s < ACC_MIN) begin
            s = ACC_MIN;
            cl_ovf = 1;
          end
        end
        cl_res = s;
        cl_cnt = (win_q.size() > CNT_MAX) ? CNT_MAX
                                          : win_q.size();
        win_q.delete();
        pend = 1;
      end
      exp_busy = (win_q.size() != 0) || pend || div;
    end
  end

  always @(negedge clk) begin
    check("m_valid", result_valid, exp_valid);
    check("m_result", $signed(result), exp_res);
    check("m_cnt", result_cnt, exp_cnt);
    check("m_ovf", result_ovf, exp_ovf);
    check("m_busy", busy, exp_busy);
  end

  task automatic step(input bit v, input int x,
                      input int y, input bit o);
    div = v;
    a   = x[W-1:0];
    b   = y[W-1:0];
    dov = o;
    @(posedge clk);
    #1;
    div = 1'b0;
    dov = 1'b0;
  endtask

  task automatic wait_emit(input string nm, input int er,
                           input int ec, input bit eo);
    for (int i = 0; i < 4; i++) begin
      if (result_valid) begin
        check({nm, "_res"}, $signed(result), er);
        check({nm, "_cnt"}, result_cnt, ec);
        check({nm, "_ovf"}, result_ovf, eo);
        return;
      end
      step(0, 0, 0, 0);
    end
    check({nm, "_timeout"}, 0, 1);
  endtask

  initial begin
    // Reset held while strobing.
    step(1, 5, 5, 1);
    step(1, 5, 5, 0);
    step(0, 0, 0, 1);
    check("rst_result", result, 0);
    check("rst_valid", result_valid, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    step(0, 0, 0, 0);
    check("rel_result", result, 0);
    check("rel_cnt", result_cnt, 0);
    check("rel_valid", result_valid, 0);

    // Basic window with emit latency.
    step(1, 3, 4, 0);
    step(1, -2, 5, 0);
    step(1, 7, 7, 0);
    step(0, 0, 0, 1);
    check("lat_edge1", result_valid, 0);
    step(0, 0, 0, 0);
    check("lat_edge2", result_valid, 1);
    check("basic_res", $signed(result), 51);
    check("basic_cnt", result_cnt, 3);
    check("basic_ovf", result_ovf, 0);
    step(0, 0, 0, 0);
    check("pulse_one", result_valid, 0);

    // Saturation and the clean window after it.
    for (int i = 0; i < 64; i++) step(1, -128, -128, 0);
    step(0, 0, 0, 1);
    wait_emit("sat", 524287, 64, 1);
    step(1, 1, 1, 0);
    step(0, 0, 0, 1);
    wait_emit("post_sat", 1, 1, 0);

    // Sample coincident with the close is included.
    step(1, 2, 3, 0);
    step(1, 4, 5, 1);
    wait_emit("simul", 26, 2, 0);

    // Sample and close during drain.
    step(0, 0, 0, 1);
    step(1, 6, 6, 1);
    wait_emit("drain_prev", 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      check("no_extra", result_valid, 0);
    end
    step(0, 0, 0, 1);
    wait_emit("drain_next", 36, 1, 0);

    // Empty flush.
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    wait_emit("empty", 0, 0, 0);

    // Reset mid-window discards it.
    step(1, 1, 2, 0);
    step(1, 3, 4, 0);
    rst = 1'b0;
    step(0, 0, 0, 0);
    check("midrst_busy", busy, 0);
    check("midrst_valid", result_valid, 0);
    rst = 1'b1;
    step(1, 1, 9, 0);
    step(0, 0, 0, 1);
    wait_emit("midrst", 9, 1, 0);

    // Negative saturation.
    for (int i = 0; i < 40; i++) step(1, -128, 127, 0);
    step(0, 0, 0, 1);
    wait_emit("neg_sat", -524288, 40, 1);

    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_mac_accum.md
# pe_mac_accum

Windowed signed multiply-accumulate stage that sits directly downstream of `metronome` in the PE datapath. `metronome` produces the per-sample strobe `data_in_valid` and the window-close strobe `data_out_valid`. This block multiplies one operand pair per `data_in_valid`, accumulates the products with saturation, and on each `data_out_valid` emits the window sum, the sample count and an overflow flag, then starts a fresh window.

## Interface
- `WIDTH`, 8, operand width; signed two's complement. Matches the `metronome` width parameter.
- `ACC_WIDTH`, 20, accumulator and result width; signed. Must be ≥ 2*WIDTH.
- `CNT_WIDTH`, 8, width of the per-window sample counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `data_in_valid` in 1: sample strobe from `metronome`; `a_in`/`b_in` are valid in the same cycle.
- `data_out_valid` in 1: window-close strobe from `metronome`.
- `a_in` in WIDTH: signed operand A.
- `b_in` in WIDTH: signed operand B.
- `result` out ACC_WIDTH: signed window sum; held until the next emit.
- `result_cnt` out CNT_WIDTH: number of samples in the emitted window; saturates at all-ones.
- `result_ovf` out 1: the emitted window saturated at least once.
- `result_valid` out 1: one-cycle pulse when `result`, `result_cnt` and `result_ovf` update.
- `busy` out 1: high when state ≠ IDLE or a product is in flight.

## Operation
- **Stage 1 (multiply).** At an edge where `data_in_valid`=1:
  - `prod_r` <= a_in*b_in, full 2*WIDTH signed.
  - `p_v` <= 1; otherwise `p_v` <= 0.
- **Stage 2 (accumulate).** At an edge where `p_v`=1 and state ≠ DRAIN:
  - `acc` <= sat(acc + sext(prod_r)).
  - `cnt` <= cnt+1, saturating.
- **Saturation.**
  - The sum is computed at ACC_WIDTH+1 bits.
  - Values above 2^(ACC_WIDTH-1)-1 clamp to that maximum; values below -2^(ACC_WIDTH-1) clamp to that minimum.
  - Any clamp sets the sticky `ovf_r`.
- **State machine.**
  - IDLE -> ACCUM on `data_in_valid`.
  - IDLE or ACCUM -> DRAIN on `data_out_valid`. This has priority over `data_in_valid` for the state decision, but the sample is still captured.
  - DRAIN -> ACCUM if `data_in_valid` is sampled at the exit edge; otherwise DRAIN -> IDLE.
- **DRAIN exit edge (always exactly one cycle in DRAIN).**
  - `result` <= sat(acc + (p_v ? prod_r : 0)).
  - `result_cnt` <= cnt + p_v, saturating.
  - `result_ovf` <= ovf_r OR (overflow of this final add).
  - `result_valid` <= 1.
  - `acc`, `cnt` and `ovf_r` clear to 0.
- **Strobe handling at DRAIN and on flush.**
  - A `data_in_valid` sampled at the DRAIN exit edge belongs to the next window. Its product lands in the freshly cleared `acc` one edge later.
  - `data_out_valid` sampled while in DRAIN is ignored; no second emit.
  - A flush from IDLE with nothing pending emits `result`=0, `result_cnt`=0, `result_ovf`=0.

## Timing
- **Reset values.** Asserting `rst` immediately forces:
  - `result`=0, `result_cnt`=0, `result_ovf`=0, `result_valid`=0, `busy`=0.
  - `acc`=0, `cnt`=0, `p_v`=0, state=IDLE.
- **Reset mid-window.** The window is discarded and no `result_valid` is produced. After `rst` deasserts, operation resumes on the next edge.
- **Sample latency.** A sample taken at edge N is in `acc` after edge N+1.
- **Emit latency.** `data_out_valid` sampled at edge N -> `result_valid` high for exactly the cycle after edge N+1.
- **Strobe boundaries.**
  - A sample presented at edge N together with `data_out_valid` is included in that window.
  - `result_valid` is never high two consecutive cycles.
- **No backpressure.** Every strobe is accepted, with the exception of the ignored `data_out_valid` during DRAIN.

## Test plan
- **Reset.** Hold `rst`=0 while driving strobes -> all outputs 0 and `busy`=0. After release, the first cycle outputs are still 0.
- **Basic window.** Samples (3,4), (-2,5), (7,7) on separate cycles, then `data_out_valid` -> `result`=51, `result_cnt`=3, `result_ovf`=0. `result_valid` is high for one cycle, 2 edges after the strobe.
- **Saturation** (defaults). 64 samples of (-128,-128) -> `result`=524287, `result_cnt`=64, `result_ovf`=1. The next window of (1,1) -> `result`=1, `result_ovf`=0.
- **Simultaneous strobes.** Samples (2,3), then (4,5) in the same cycle as `data_out_valid` -> `result`=26, `result_cnt`=2.
- **Input during DRAIN.** `data_in_valid`=(6,6) in the cycle right after `data_out_valid` -> it is excluded from the current result. The next window emits 36, count 1. A `data_out_valid` in that same DRAIN cycle produces no extra emit.
- **Edge cases.**
  - Empty flush -> `result`=0, `result_cnt`=0.
  - `rst` pulsed after 2 samples, then 1 sample (1,9) and a flush -> `result`=9, `result_cnt`=1.
